sequential_divider: RTL and testbench

Iterative signed integer divider, the inverse companion of the team's sequential multiplier. Takes a WIDTH-bit signed dividend and divisor on a start pulse. Runs one restoring shift-subtract step per clock. Returns a signed quotient (truncated toward zero) and a remainder whose sign follows the dividend, with a one-cycle done pulse. Used wherever the datapath needs division without a combinational divider array.

---
 rtl/sequential_divider.sv | 125 ++++++++++++
 tb/tb_sequential_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Iterative signed divider: one restoring shift-subtract step per clock, WIDTH+1 busy cycles.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [WIDTH:0]   rem_sh, diff;

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom
    rem_sh      = {rem_q, dvd_q[WIDTH-1]};
    diff        = rem_sh - {1'b0, dvs_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d   = divisor[WIDTH-1]  ? -divisor  : divisor;
          qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d  = dividend[WIDTH-1];
          zero_d  = (divisor == '0);
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // With a zero divisor every trial passes, so rem_q ends as |dividend|
        quotient_d  = zero_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
        remainder_d = rneg_q ? -rem_q : rem_q;
        dbz_d       = zero_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Bench for sequential_divider: arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_sequential_divider;
  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h80000000;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: language signed / and %, with the two special cases spelled out
  task automatic ref_div(input logic signed [31:0] a, input logic signed [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output bit z);
    if (b == 0) begin
      q = 32'hFFFFFFFF; r = a; z = 1'b1;
    end else if (a == MINV && b == -1) begin
      q = MINV; r = 32'h0; z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Transaction-level model: a result appears W+1 cycles after an accepted start
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit          m_z, p_z, m_busy, m_done;
  int          m_left = 0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_left = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        ref_div(dividend, divisor, p_q, p_r, p_z);
        m_left = W + 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
      end
    end
    m_busy = (m_left > 0);
  end

  always @(negedge clk) begin
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("done", {31'b0, done}, {31'b0, m_done});
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_z});
  end

  // Called at a negedge while the DUT is idle; returns at the negedge where done is high
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit lit,
                     input logic [31:0] eq, input logic [31:0] er, input bit ez,
                     input bit intr);
    int n;
    int extra;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (intr && n == 5) begin
        dividend = 32'd81; divisor = 32'd9; start = 1'b1;
      end else start = 1'b0;
    end
    check("latency", n, W + 1);
    if (lit) begin
      check("lit_quotient", quotient, eq);
      check("lit_remainder", remainder, er);
      check("lit_dbz", {31'b0, div_by_zero}, {31'b0, ez});
    end
    if (intr) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("single_done", extra, 0);
      check("held_quotient", quotient, eq);
    end
  endtask

  initial begin
    logic [31:0] q, r;
    bit z;
    int extra;
    logic [31:0] a, b;

    ref_div(-50, 10, q, r, z);
    check("model_q1", q, -5);  check("model_r1", r, 0);
    ref_div(7, -2, q, r, z);
    check("model_q2", q, -3);  check("model_r2", r, 1);
    ref_div(-7, 2, q, r, z);
    check("model_q3", q, -3);  check("model_r3", r, -1);

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);

    run(-50, 10, 1, -5, 0, 0, 0);
    run(100, 20, 1, 5, 0, 0, 0);
    run(7, -2, 1, -3, 1, 0, 0);
    run(-7, 2, 1, -3, -1, 0, 0);
    run(-32, -8, 1, 4, 0, 0, 0);
    run(0, 30, 1, 0, 0, 0, 0);
    run(30, 0, 1, 32'hFFFFFFFF, 30, 1, 0);
    run(80, 4, 1, 20, 0, 0, 0);
    run(-30, 0, 1, 32'hFFFFFFFF, -30, 1, 0);
    run(MINV, -1, 1, MINV, 0, 0, 0);
    run(MINV, 1, 1, MINV, 0, 0, 0);
    run(32'h7FFFFFFF, MINV, 1, 0, 32'h7FFFFFFF, 0, 0);

    // start while busy is ignored; then start in the done cycle is accepted
    run(6, 6, 1, 1, 0, 0, 1);
    run(6, 6, 1, 1, 0, 0, 0);
    run(81, 9, 1, 9, 0, 0, 0);

    // reset mid-operation
    dividend = 1000; divisor = 7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midrst_no_done", extra, 0);
    run(45, -9, 1, -5, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 15) == 0) a = MINV;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        3: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run(a, b, 0, 0, 0, 0, 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
